// File: rtl/gif_pkg.sv
// Shared definitions for the GIF frame loader: FSM state encoding,
// default packet/geometry constants and the checksum type.
package gif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        DATA,
        CSUM,
        RESP
    } state_t;

    localparam int         TOTAL_FRAMES_DEF    = 4;
    localparam int         WORDS_PER_FRAME_DEF = 2048;
    localparam logic [7:0] SYNC_BYTE_DEF       = 8'hA5;
    localparam int         CSUM_W              = 8;

    typedef logic [CSUM_W-1:0] csum_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles, cleared on demand.
// Ports: clk, rst (async active-low), clear, en, expired (LIMIT-th cycle).
module loader_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // Flags the cycle that completes LIMIT consecutive idle cycles.
    assign expired = en && !clear && (count == LAST);

endmodule

// File: rtl/gif_frame_loader.sv
// Parses SYNC/index/data/checksum packets from a valid/ready byte stream,
// packs 3 bytes per 24-bit word and writes them into the selected frame slot.
// Ports: clk, rst (async active-low); rx_data/rx_valid/rx_ready byte input;
// wr_en/wr_frame/wr_addr/wr_data memory write; frame_valid per-slot status;
// load_done/load_err result pulses; busy when not idle.
module gif_frame_loader
    import gif_pkg::*;
#(
    parameter int         TOTAL_FRAMES    = TOTAL_FRAMES_DEF,
    parameter int         WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int         ADDR_WIDTH      = 11,
    parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF,
    parameter int         TIMEOUT         = 1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            wr_en,
    output logic [$clog2(TOTAL_FRAMES)-1:0] wr_frame,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [23:0]                     wr_data,
    output logic [TOTAL_FRAMES-1:0]         frame_valid,
    output logic                            load_done,
    output logic                            load_err,
    output logic                            busy
);

    localparam int FW = $clog2(TOTAL_FRAMES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(WORDS_PER_FRAME - 1);

    state_t state_q;
    state_t state_d;

    logic          live_q;
    logic [1:0]    phase_q;
    logic [7:0]    byte0_q;
    logic [7:0]    byte1_q;
    csum_t         csum_q;
    logic [FW-1:0] idx;

    logic accept;
    logic idx_ok;
    logic last_word;
    logic waiting;
    logic expired;

    logic start;
    logic take_data;
    logic do_write;
    logic go_done;
    logic go_err;

    // live_q holds rx_ready low until the first edge after reset release.
    assign rx_ready  = live_q && (state_q != RESP);
    assign busy      = (state_q != IDLE);
    assign accept    = rx_valid && rx_ready;
    assign idx       = rx_data[FW-1:0];
    assign idx_ok    = int'(rx_data) < TOTAL_FRAMES;
    assign last_word = (wr_addr == LAST_ADDR);
    assign waiting   = (state_q == FRAME) || (state_q == DATA) ||
                       (state_q == CSUM);

    loader_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept || !waiting),
        .en     (waiting),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        take_data = 1'b0;
        do_write  = 1'b0;
        go_done   = 1'b0;
        go_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = FRAME;
                end
            end
            FRAME: begin
                if (accept) begin
                    if (idx_ok) begin
                        start   = 1'b1;
                        state_d = DATA;
                    end else begin
                        go_err  = 1'b1;
                        state_d = RESP;
                    end
                end else if (expired) begin
                    go_err  = 1'b1;
                    state_d = RESP;
                end
            end
            DATA: begin
                if (accept) begin
                    take_data = 1'b1;
                    if (phase_q == 2'd2) begin
                        do_write = 1'b1;
                        if (last_word) begin
                            state_d = CSUM;
                        end
                    end
                end else if (expired) begin
                    go_err  = 1'b1;
                    state_d = RESP;
                end
            end
            CSUM: begin
                if (accept) begin
                    go_done = (rx_data == csum_q);
                    go_err  = (rx_data != csum_q);
                    state_d = RESP;
                end else if (expired) begin
                    go_err  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q      <= 1'b0;
            wr_en       <= 1'b0;
            wr_frame    <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_valid <= '0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            phase_q     <= 2'd0;
            byte0_q     <= 8'h00;
            byte1_q     <= 8'h00;
            csum_q      <= '0;
        end else begin
            live_q    <= 1'b1;
            wr_en     <= do_write;
            load_done <= go_done;
            load_err  <= go_err;
            if (start) begin
                wr_frame         <= idx;
                frame_valid[idx] <= 1'b0;
                phase_q          <= 2'd0;
                wr_addr          <= '0;
                csum_q           <= '0;
            end else begin
                // Address advances once the write strobe has been seen.
                if (wr_en) begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
                if (take_data) begin
                    csum_q <= csum_q + rx_data;
                    unique case (phase_q)
                        2'd0:    byte0_q <= rx_data;
                        2'd1:    byte1_q <= rx_data;
                        default: wr_data <= {byte0_q, byte1_q, rx_data};
                    endcase
                    phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                end
            end
            if (go_done) begin
                frame_valid[wr_frame] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gif_frame_loader.sv
// Self-checking bench for gif_frame_loader: table-driven packets,
// timeout and async-reset sequences, then randomized packets.
module tb_gif_frame_loader;

    localparam int         NF   = 4;
    localparam int         NW   = 2048;
    localparam int         AW   = 11;
    localparam int         TO   = 16;
    localparam int         NB   = 3 * NW;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          wr_en;
    logic [1:0]    wr_frame;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [NF-1:0] frame_valid;
    logic          load_done;
    logic          load_err;
    logic          busy;

    always #5 clk = ~clk;

    gif_frame_loader #(
        .TOTAL_FRAMES   (NF),
        .WORDS_PER_FRAME(NW),
        .ADDR_WIDTH     (AW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT        (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_frame   (wr_frame),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_valid(frame_valid),
        .load_done  (load_done),
        .load_err   (load_err),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0]    f;
        logic [AW-1:0] a;
        logic [23:0]   d;
    } wr_t;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] cdelta;
        bit         garbage;
        int         exp_wr;
        int         exp_done;
        int         exp_err;
        logic [3:0] exp_mid;
        logic [3:0] exp_fv;
    } vec_t;

    wr_t        wr_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] pkt[NB];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] exp_fv;

    always @(negedge clk) begin
        if (wr_en) wr_q.push_back('{f: wr_frame, a: wr_addr, d: wr_data});
        if (load_done) done_cnt++;
        if (load_err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rgap(input bit rnd);
        if (!rnd) return 0;
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        g = 0;
        while (!rx_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            chk("xfer_stuck", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_packet(input logic [7:0] idx, input bit ramp,
                              input logic [7:0] cdelta, input bit garbage,
                              input bit rnd, output logic [3:0] fv_mid);
        logic [7:0] sum;
        sum = 8'h00;
        if (garbage) begin
            send_byte(8'h00, 0);
            send_byte(8'h13, 0);
            chk("garbage_idle", busy, 0);
        end
        send_byte(SYNC, rgap(rnd));
        send_byte(idx, rgap(rnd));
        fv_mid = frame_valid;
        if (int'(idx) < NF) begin
            for (int i = 0; i < NB; i++) begin
                pkt[i] = ramp ? 8'(i) : 8'($urandom);
                sum += pkt[i];
                send_byte(pkt[i], rgap(rnd));
            end
            send_byte(sum + cdelta, rgap(rnd));
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_writes(input logic [7:0] idx, input int base,
                                input int exp_n);
        int  bad;
        int  n;
        wr_t w;
        bad = 0;
        n = wr_q.size() - base;
        chk("wr_count", n, exp_n);
        if (n == exp_n) begin
            for (int k = 0; k < exp_n; k++) begin
                w = wr_q[base + k];
                if (w.f !== idx[1:0] || w.a !== AW'(k) ||
                    w.d !== {pkt[3*k], pkt[3*k+1], pkt[3*k+2]}) bad++;
            end
        end
        chk("wr_words", bad, 0);
    endtask

    initial begin
        vec_t       tbl[6];
        logic [3:0] mid;
        logic [3:0] exp_mid;
        logic [7:0] ridx;
        logic [7:0] rdel;
        int         d0;
        int         e0;
        int         base;
        int         n;

        tbl[0] = '{8'd2, 8'd0, 1'b0, NW, 1, 0, 4'b0000, 4'b0100};
        tbl[1] = '{8'd2, 8'd1, 1'b0, NW, 0, 1, 4'b0000, 4'b0000};
        tbl[2] = '{8'd4, 8'd0, 1'b0, 0,  0, 1, 4'b0000, 4'b0000};
        tbl[3] = '{8'd1, 8'd0, 1'b0, NW, 1, 0, 4'b0000, 4'b0010};
        tbl[4] = '{8'd0, 8'd0, 1'b1, NW, 1, 0, 4'b0010, 4'b0011};
        tbl[5] = '{8'd0, 8'd0, 1'b1, NW, 1, 0, 4'b0010, 4'b0011};

        #3;
        chk("rst_ready", rx_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_ready_low", rx_ready, 0);
        @(negedge clk);
        chk("rel_ready_high", rx_ready, 1);

        for (int t = 0; t < 6; t++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            base = wr_q.size();
            run_packet(tbl[t].idx, 1'b1, tbl[t].cdelta, tbl[t].garbage,
                       1'b0, mid);
            chk("tbl_mid_fv", mid, tbl[t].exp_mid);
            chk("tbl_done", done_cnt - d0, tbl[t].exp_done);
            chk("tbl_err", err_cnt - e0, tbl[t].exp_err);
            chk("tbl_fv", frame_valid, tbl[t].exp_fv);
            chk("tbl_idle", busy, 0);
            check_writes(tbl[t].idx, base, tbl[t].exp_wr);
            if (tbl[t].exp_wr == NW && wr_q.size() - base == NW) begin
                chk("tbl_word0", wr_q[base].d, 24'h000102);
                chk("tbl_wordlast", wr_q[base + NW - 1].d, 24'hFDFEFF);
            end
        end
        exp_fv = 4'b0011;

        // Stall inside DATA until the watchdog fires.
        e0 = err_cnt;
        base = wr_q.size();
        send_byte(SYNC, 0);
        send_byte(8'd3, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 7), 0);
        n = 0;
        while (!load_err && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_ready_low", rx_ready, 0);
        chk("to_busy", busy, 1);
        @(negedge clk);
        chk("to_ready_back", rx_ready, 1);
        chk("to_idle", busy, 0);
        chk("to_err", err_cnt - e0, 1);
        chk("to_writes", wr_q.size() - base, 3);
        chk("to_fv", frame_valid, exp_fv);

        // Asynchronous reset in the middle of frame 1.
        send_byte(SYNC, 0);
        send_byte(8'd1, 0);
        for (int i = 0; i <= 1500; i++) send_byte(8'(i), 0);
        chk("mid_addr", wr_addr, 500);
        chk("mid_data", wr_data, 24'hD9DADB);
        chk("mid_fv", frame_valid, 4'b0001);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", rx_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", wr_addr, 0);
        chk("arst_data", wr_data, 0);
        chk("arst_frame", wr_frame, 0);
        chk("arst_fv", frame_valid, 0);
        chk("arst_pulses", {wr_en, load_done, load_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", rx_ready, 1);
        exp_fv = 4'b0000;

        for (int r = 0; r < 3; r++) begin
            ridx = 8'($urandom_range(0, 5));
            rdel = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255))
                                               : 8'd0;
            exp_mid = exp_fv;
            if (int'(ridx) < NF) begin
                exp_mid = exp_fv & ~(4'b0001 << ridx);
                exp_fv = exp_mid | ((rdel == 0) ? (4'b0001 << ridx) : 4'b0);
            end
            d0 = done_cnt;
            e0 = err_cnt;
            base = wr_q.size();
            run_packet(ridx, 1'b0, rdel, 1'b0, 1'b1, mid);
            chk("rnd_mid_fv", mid, exp_mid);
            chk("rnd_fv", frame_valid, exp_fv);
            chk("rnd_done", done_cnt - d0,
                (int'(ridx) < NF && rdel == 0) ? 1 : 0);
            chk("rnd_err", err_cnt - e0,
                (int'(ridx) < NF && rdel == 0) ? 0 : 1);
            check_writes(ridx, base, (int'(ridx) < NF) ? NW : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
